wb_spi_xip_ctrl: RTL and testbench
==================================

// Module: wb_spi_xip_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the minimal SPI master. Turns Wishbone fetch
//  requests into SPI-flash READ (0x03) transactions: a 32-bit cmd+addr
//  transfer, then a 32-bit dummy transfer. Returns the byte-swapped word.
//  Shares the SPI master with a direct software port; XIP always has priority.
// PARAMETERS
//  CMD_READ  8'h03  flash read opcode placed in bits [31:24] of the cmd word
// PORTS
//  clk_i        in   1   clock
//  rst_in       in   1   synchronous reset, active low
//  xip_cyc_i    in   1   XIP Wishbone cycle
//  xip_stb_i    in   1   XIP Wishbone strobe (read only)
//  xip_adr_i    in   24  XIP byte address; [1:0] ignored
//  xip_ack_o    out  1   XIP ack, one-cycle pulse
//  xip_dat_o    out  32  XIP read data, valid with xip_ack_o
//  dir_cyc_i    in   1   direct-port Wishbone cycle
//  dir_stb_i    in   1   direct-port strobe
//  dir_we_i     in   1   direct-port write: 1 = start a transfer, 0 = read rx
//  dir_dat_i    in   32  direct-port tx word
//  dir_dat_o    out  32  direct-port rx word (= spi_dat_i)
//  dir_ack_o    out  1   direct-port ack
//  dir_size_i   in   2   transfer size (bytes-1) for direct writes
//  dir_cs_i     in   1   software CS level (active low) outside XIP
//  spi_cyc_o    out  1   to SPI master wb_spi_cyc_i
//  spi_stb_o    out  1   to SPI master wb_spi_stb_i
//  spi_we_o     out  1   to SPI master wb_spi_we_i
//  spi_dat_o    out  32  to SPI master wb_spi_dat_i
//  spi_dat_i    in   32  from SPI master wb_spi_dat_o (rx shift register)
//  spi_ack_i    in   1   from SPI master wb_spi_ack_o
//  spi_rdy_i    in   1   from SPI master rdy_o (master idle)
//  spi_size_o   out  2   to SPI master size_i
//  spi_cs_o     out  1   flash CS, active low (SPI master auto_cs_i tied 0)
// BEHAVIOUR
//  - Reset: state IDLE. xip_ack_o=0, dir_ack_o=0, spi_cyc_o=spi_stb_o=spi_we_o=0,
//    spi_dat_o=0, spi_size_o=dir_size_i, spi_cs_o=1 (cs_r register).
//  - FSM: IDLE, CMD, CMD_W, DAT, DAT_W, RESP.
//  - IDLE: xip_cyc_i&xip_stb_i&spi_rdy_i -> CMD; latch adr; cs_r<=0.
//    Direct write is ignored in the cycle an XIP request is accepted.
//  - CMD: cyc=stb=we=1, spi_dat_o={CMD_READ,adr[23:2],2'b00}, size=2'd3.
//    The master acks combinationally, so CMD lasts 1 cycle -> CMD_W.
//  - CMD_W: outputs idle; wait for spi_rdy_i=1 -> DAT. The master drops rdy the
//    cycle after the strobe, so rdy is already 0 on CMD_W entry.
//  - DAT: cyc=stb=we=1, spi_dat_o=32'h0, size=2'd3, 1 cycle -> DAT_W.
//  - DAT_W: wait for spi_rdy_i=1 -> RESP.
//  - RESP: xip_ack_o=1 for exactly 1 cycle.
//    xip_dat_o={spi_dat_i[7:0],spi_dat_i[15:8],spi_dat_i[23:16],spi_dat_i[31:24]}.
//    cs_r<=1 -> IDLE.
//  - CS stays low from the CMD cycle through RESP, continuous across both
//    transfers. In IDLE, cs_r<=dir_cs_i (1-cycle lag).
//  - Direct port, combinational, only in IDLE with no XIP request:
//      read  (we=0): dir_ack_o=1, no SPI access, dir_dat_o=spi_dat_i.
//      write (we=1): forwarded when spi_rdy_i=1: spi_* = dir_*, size=dir_size_i,
//      dir_ack_o=spi_ack_i. If spi_rdy_i=0, no ack and no forwarding (stall).
//  - Direct requests outside IDLE get no ack (stall) until return to IDLE.
//  - XIP request with spi_rdy_i=0 (direct transfer running) waits in IDLE.
//  - xip_cyc_i dropping mid-sequence does not abort; the ack is still issued.
//  - Reset mid-sequence: back to IDLE with CS high on the next cycle; no ack.
// TESTING
//  1 XIP adr 0x000107; flash model returns 11,22,33,44 -> cmd word 0x03000104,
//    then 0x00000000; xip_dat_o=0x44332211; single ack; CS low whole sequence.
//  2 XIP and direct write asserted in the same IDLE cycle -> XIP runs first.
//    The direct write stalls, then is forwarded after RESP, with its dir_dat_i.
//  3 Direct write 0xA5000000, size 0, then a direct write while busy -> second
//    write gets no ack until spi_rdy_i=1. Direct read -> immediate ack, rx data.
//  4 XIP request during a direct transfer -> held in IDLE until spi_rdy_i=1.
//    Then CMD follows and cs_r=0.
//  5 rst_in low during DAT_W -> next cycle IDLE, spi_cs_o=1, no xip_ack_o.
//    A new XIP request then completes normally.
//  6 Back-to-back XIP reads 0x000000, 0x000004 -> two distinct acks.
//    CS deasserts at least 1 cycle between them.

Source files
------------

// File: rtl/wb_spi_xip_ctrl.sv
// XIP sequencer in front of a minimal SPI master: turns Wishbone fetches into
// READ (cmd+addr, dummy) transfer pairs and shares the master with a direct port.
module wb_spi_xip_ctrl #(
   parameter logic [7:0] CMD_READ = 8'h03
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic        xip_cyc_i,
   input  logic        xip_stb_i,
   input  logic [23:0] xip_adr_i,
   output logic        xip_ack_o,
   output logic [31:0] xip_dat_o,
   input  logic        dir_cyc_i,
   input  logic        dir_stb_i,
   input  logic        dir_we_i,
   input  logic [31:0] dir_dat_i,
   output logic [31:0] dir_dat_o,
   output logic        dir_ack_o,
   input  logic [1:0]  dir_size_i,
   input  logic        dir_cs_i,
   output logic        spi_cyc_o,
   output logic        spi_stb_o,
   output logic        spi_we_o,
   output logic [31:0] spi_dat_o,
   input  logic [31:0] spi_dat_i,
   input  logic        spi_ack_i,
   input  logic        spi_rdy_i,
   output logic [1:0]  spi_size_o,
   output logic        spi_cs_o
);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_CMD_W, S_DAT, S_DAT_W, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [21:0] r_adr;
   logic        r_cs;
   logic        w_xip_req;
   logic        w_dir_req;
   logic        w_accept;
   logic        w_unused;

   assign w_xip_req = xip_cyc_i & xip_stb_i;
   assign w_dir_req = dir_cyc_i & dir_stb_i;
   assign w_accept  = (r_state == S_IDLE) & w_xip_req & spi_rdy_i;
   assign w_unused  = &{1'b0, xip_adr_i[1:0]};

   assign spi_cs_o  = r_cs;
   assign dir_dat_o = spi_dat_i;
   // Flash shifts bytes out MSB-first; the fetch wants little-endian order.
   assign xip_dat_o = {spi_dat_i[7:0], spi_dat_i[15:8], spi_dat_i[23:16], spi_dat_i[31:24]};

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         r_state <= S_IDLE;
         r_cs    <= 1'b1;
         r_adr   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) r_adr <= xip_adr_i[23:2];
         // CS held low across both transfers so the flash sees one READ.
         case (r_state)
            S_IDLE:  r_cs <= w_accept ? 1'b0 : dir_cs_i;
            S_RESP:  r_cs <= 1'b1;
            default: r_cs <= 1'b0;
         endcase
      end
   end

   always_comb begin
      w_next     = r_state;
      spi_cyc_o  = 1'b0;
      spi_stb_o  = 1'b0;
      spi_we_o   = 1'b0;
      spi_dat_o  = '0;
      spi_size_o = dir_size_i;
      xip_ack_o  = 1'b0;
      dir_ack_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_CMD;
            end else if (w_dir_req && !w_xip_req) begin
               if (!dir_we_i) begin
                  dir_ack_o = 1'b1;
               end else if (spi_rdy_i) begin
                  spi_cyc_o = 1'b1;
                  spi_stb_o = 1'b1;
                  spi_we_o  = dir_we_i;
                  spi_dat_o = dir_dat_i;
                  dir_ack_o = spi_ack_i;
               end
            end
         end
         S_CMD: begin
            spi_cyc_o  = 1'b1;
            spi_stb_o  = 1'b1;
            spi_we_o   = 1'b1;
            spi_dat_o  = {CMD_READ, r_adr, 2'b00};
            spi_size_o = 2'd3;
            w_next     = S_CMD_W;
         end
         S_CMD_W: if (spi_rdy_i) w_next = S_DAT;
         S_DAT: begin
            spi_cyc_o  = 1'b1;
            spi_stb_o  = 1'b1;
            spi_we_o   = 1'b1;
            spi_size_o = 2'd3;
            w_next     = S_DAT_W;
         end
         S_DAT_W: if (spi_rdy_i) w_next = S_RESP;
         S_RESP: begin
            xip_ack_o = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_spi_xip_ctrl.sv
// Bench for wb_spi_xip_ctrl: behavioural SPI master/flash model, table of XIP
// fetches, and directed sequences for arbitration, stall and reset corners.
module tb_wb_spi_xip_ctrl;

   bit          clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_in;
   logic        xip_cyc_i, xip_stb_i;
   logic [23:0] xip_adr_i;
   logic        xip_ack_o;
   logic [31:0] xip_dat_o;
   logic        dir_cyc_i, dir_stb_i, dir_we_i;
   logic [31:0] dir_dat_i, dir_dat_o;
   logic        dir_ack_o;
   logic [1:0]  dir_size_i;
   logic        dir_cs_i;
   logic        spi_cyc_o, spi_stb_o, spi_we_o;
   logic [31:0] spi_dat_o, spi_dat_i;
   logic        spi_ack_i, spi_rdy_i;
   logic [1:0]  spi_size_o;
   logic        spi_cs_o;

   wb_spi_xip_ctrl dut (
      .clk_i(clk), .rst_in(rst_in),
      .xip_cyc_i(xip_cyc_i), .xip_stb_i(xip_stb_i), .xip_adr_i(xip_adr_i),
      .xip_ack_o(xip_ack_o), .xip_dat_o(xip_dat_o),
      .dir_cyc_i(dir_cyc_i), .dir_stb_i(dir_stb_i), .dir_we_i(dir_we_i),
      .dir_dat_i(dir_dat_i), .dir_dat_o(dir_dat_o), .dir_ack_o(dir_ack_o),
      .dir_size_i(dir_size_i), .dir_cs_i(dir_cs_i),
      .spi_cyc_o(spi_cyc_o), .spi_stb_o(spi_stb_o), .spi_we_o(spi_we_o),
      .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i), .spi_ack_i(spi_ack_i),
      .spi_rdy_i(spi_rdy_i), .spi_size_o(spi_size_o), .spi_cs_o(spi_cs_o)
   );

   // SPI master + flash model: combinational ack when idle, busy 4 cycles,
   // rx = flash word for an all-zero (dummy) tx word, else ~tx.
   bit          m_rst_n;
   logic [31:0] m_flash;
   logic [31:0] m_pend;
   logic [2:0]  m_cnt;
   logic [31:0] tx_q[$];
   logic [1:0]  sz_q[$];

   assign spi_ack_i = spi_cyc_o & spi_stb_o & spi_rdy_i;

   always @(posedge clk) begin
      if (!m_rst_n) begin
         spi_rdy_i <= 1'b1;
         m_cnt     <= '0;
         spi_dat_i <= '0;
         m_pend    <= '0;
      end else if (spi_ack_i) begin
         spi_rdy_i <= 1'b0;
         m_cnt     <= 3'd4;
         m_pend    <= (spi_dat_o == 32'h0) ? m_flash : ~spi_dat_o;
         tx_q.push_back(spi_dat_o);
         sz_q.push_back(spi_size_o);
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 3'd1;
         if (m_cnt == 3'd1) begin
            spi_rdy_i <= 1'b1;
            spi_dat_i <= m_pend;
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!spi_rdy_i && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_wait", {31'b0, spi_rdy_i}, 32'd1);
   endtask

   // Issues one XIP fetch starting at the current negedge and waits for its ack.
   task automatic xip_read(input logic [23:0] adr, output logic [31:0] dat,
                           output int cs_hi, output bit cs_ok, output bit tmo,
                           output int dacks);
      bit started = 1'b0;
      tx_q.delete();
      sz_q.delete();
      cs_hi = 0; cs_ok = 1'b1; tmo = 1'b1; dacks = 0; dat = '0;
      xip_adr_i = adr; xip_cyc_i = 1'b1; xip_stb_i = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (spi_stb_o) started = 1'b1;
         if (!started && spi_cs_o) cs_hi++;
         if (started && spi_cs_o) cs_ok = 1'b0;
         if (dir_ack_o) dacks++;
         if (xip_ack_o) begin
            dat = xip_dat_o;
            tmo = 1'b0;
            break;
         end
      end
      xip_cyc_i = 1'b0; xip_stb_i = 1'b0;
   endtask

   typedef struct {
      logic [23:0] adr;
      logic [31:0] flash;
      logic [31:0] cmd;
      logic [31:0] dat;
   } vec_t;
   vec_t vt[4];

   logic [31:0] d;
   int          cs_hi, dacks, acks, waited;
   bit          cs_ok, tmo, got, early, hold_bad;

   initial begin
      vt[0] = '{24'h000107, 32'h11223344, 32'h03000104, 32'h44332211};
      vt[1] = '{24'hFFFFFF, 32'hDEADBEEF, 32'h03FFFFFC, 32'hEFBEADDE};
      vt[2] = '{24'h000000, 32'hA1B2C3D4, 32'h03000000, 32'hD4C3B2A1};
      vt[3] = '{24'h000004, 32'h01020304, 32'h03000004, 32'h04030201};

      m_rst_n = 1'b0; rst_in = 1'b0; m_flash = '0;
      xip_cyc_i = 1'b0; xip_stb_i = 1'b0; xip_adr_i = '0;
      dir_cyc_i = 1'b0; dir_stb_i = 1'b0; dir_we_i = 1'b0; dir_dat_i = '0;
      dir_size_i = 2'd2; dir_cs_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cs", {31'b0, spi_cs_o}, 32'd1);
      chk("rst_xip_ack", {31'b0, xip_ack_o}, 32'd0);
      chk("rst_dir_ack", {31'b0, dir_ack_o}, 32'd0);
      chk("rst_spi_ctl", {29'b0, spi_cyc_o, spi_stb_o, spi_we_o}, 32'd0);
      chk("rst_spi_dat", spi_dat_o, 32'h0);
      chk("rst_size", {30'b0, spi_size_o}, 32'd2);
      m_rst_n = 1'b1; rst_in = 1'b1; dir_size_i = 2'd0;

      // software CS follows dir_cs_i one cycle late
      @(negedge clk);
      dir_cs_i = 1'b0; #1;
      chk("cs_lag_hold", {31'b0, spi_cs_o}, 32'd1);
      @(negedge clk);
      chk("cs_lag_low", {31'b0, spi_cs_o}, 32'd0);
      dir_cs_i = 1'b1;
      @(negedge clk);
      chk("cs_lag_high", {31'b0, spi_cs_o}, 32'd1);

      // back-to-back XIP fetches from the table
      for (int i = 0; i < 4; i++) begin
         m_flash = vt[i].flash;
         xip_read(vt[i].adr, d, cs_hi, cs_ok, tmo, dacks);
         chk($sformatf("v%0d_timeout", i), {31'b0, tmo}, 32'd0);
         chk($sformatf("v%0d_dat", i), d, vt[i].dat);
         chk($sformatf("v%0d_cs_low", i), {31'b0, cs_ok}, 32'd1);
         chk($sformatf("v%0d_ntx", i), tx_q.size(), 32'd2);
         if (tx_q.size() == 2) begin
            chk($sformatf("v%0d_cmd", i), tx_q[0], vt[i].cmd);
            chk($sformatf("v%0d_dummy", i), tx_q[1], 32'h0);
            chk($sformatf("v%0d_size", i), {28'b0, sz_q[0], sz_q[1]}, 32'hF);
         end
         if (i > 0) chk($sformatf("v%0d_cs_gap", i), {31'b0, cs_hi >= 1}, 32'd1);
      end
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (xip_ack_o) acks++;
      end
      chk("single_ack", acks, 32'd0);

      // XIP and direct write in the same cycle: XIP wins, write follows
      wait_rdy();
      dir_cyc_i = 1'b1; dir_stb_i = 1'b1; dir_we_i = 1'b1;
      dir_dat_i = 32'hCAFEF00D; dir_size_i = 2'd1; m_flash = 32'h55667788;
      xip_read(24'h000010, d, cs_hi, cs_ok, tmo, dacks);
      chk("t2_dat", d, 32'h88776655);
      chk("t2_dir_stall", dacks, 32'd0);
      got = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (dir_ack_o) begin got = 1'b1; break; end
      end
      chk("t2_dir_ack", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
      dir_cyc_i = 1'b0; dir_stb_i = 1'b0;
      @(negedge clk);
      chk("t2_ntx", tx_q.size(), 32'd3);
      if (tx_q.size() == 3) begin
         chk("t2_first_cmd", tx_q[0], 32'h03000010);
         chk("t2_dir_tx", tx_q[2], 32'hCAFEF00D);
         chk("t2_dir_size", {30'b0, sz_q[2]}, 32'd1);
      end

      // direct write, second write stalls while busy, then direct read
      wait_rdy();
      tx_q.delete(); sz_q.delete();
      dir_cyc_i = 1'b1; dir_stb_i = 1'b1; dir_we_i = 1'b1;
      dir_dat_i = 32'hA5000000; dir_size_i = 2'd0; #1;
      chk("t3_w1_ack", {31'b0, dir_ack_o}, 32'd1);
      @(posedge clk); #1;
      dir_dat_i = 32'h12345678; dir_size_i = 2'd2;
      @(negedge clk);
      chk("t3_w2_stall", {31'b0, dir_ack_o}, 32'd0);
      got = 1'b0; early = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (dir_ack_o) begin
            if (!spi_rdy_i) early = 1'b1;
            got = 1'b1;
            break;
         end
      end
      chk("t3_w2_ack", {31'b0, got}, 32'd1);
      chk("t3_w2_early", {31'b0, early}, 32'd0);
      @(posedge clk); #1;
      dir_cyc_i = 1'b0; dir_stb_i = 1'b0;
      wait_rdy();
      chk("t3_ntx", tx_q.size(), 32'd2);
      if (tx_q.size() == 2) begin
         chk("t3_tx0", tx_q[0], 32'hA5000000);
         chk("t3_sz0", {30'b0, sz_q[0]}, 32'd0);
         chk("t3_tx1", tx_q[1], 32'h12345678);
         chk("t3_sz1", {30'b0, sz_q[1]}, 32'd2);
      end
      dir_cyc_i = 1'b1; dir_stb_i = 1'b1; dir_we_i = 1'b0; #1;
      chk("t3_rd_ack", {31'b0, dir_ack_o}, 32'd1);
      chk("t3_rd_dat", dir_dat_o, 32'hEDCBA987);
      chk("t3_rd_nospi", {31'b0, spi_stb_o}, 32'd0);
      @(posedge clk); #1;
      dir_cyc_i = 1'b0; dir_stb_i = 1'b0;

      // XIP request during a direct transfer waits for rdy
      @(negedge clk);
      dir_cyc_i = 1'b1; dir_stb_i = 1'b1; dir_we_i = 1'b1; dir_dat_i = 32'h0F0F0F0F; #1;
      chk("t4_dir_ack", {31'b0, dir_ack_o}, 32'd1);
      @(posedge clk); #1;
      dir_cyc_i = 1'b0; dir_stb_i = 1'b0;
      tx_q.delete(); sz_q.delete();
      m_flash = 32'h0A0B0C0D; xip_adr_i = 24'h000208; xip_cyc_i = 1'b1; xip_stb_i = 1'b1;
      waited = 0; hold_bad = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (spi_rdy_i) break;
         waited++;
         if (spi_stb_o || !spi_cs_o) hold_bad = 1'b1;
      end
      chk("t4_waited", {31'b0, waited > 0}, 32'd1);
      chk("t4_hold_idle", {31'b0, hold_bad}, 32'd0);
      @(negedge clk);
      chk("t4_cmd_stb", {31'b0, spi_stb_o}, 32'd1);
      chk("t4_cmd_word", spi_dat_o, 32'h03000208);
      chk("t4_cmd_cs", {31'b0, spi_cs_o}, 32'd0);
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (xip_ack_o) begin got = 1'b1; break; end
      end
      chk("t4_ack", {31'b0, got}, 32'd1);
      chk("t4_dat", xip_dat_o, 32'h0D0C0B0A);
      xip_cyc_i = 1'b0; xip_stb_i = 1'b0;

      // reset during DAT_W aborts without ack; next fetch completes
      wait_rdy();
      tx_q.delete(); sz_q.delete();
      m_flash = 32'h99999999; xip_adr_i = 24'h000100; xip_cyc_i = 1'b1; xip_stb_i = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (tx_q.size() == 2) break;
      end
      chk("t5_reach_datw", tx_q.size(), 32'd2);
      rst_in = 1'b0; xip_cyc_i = 1'b0; xip_stb_i = 1'b0;
      @(negedge clk);
      chk("t5_cs_high", {31'b0, spi_cs_o}, 32'd1);
      chk("t5_no_ack", {31'b0, xip_ack_o}, 32'd0);
      rst_in = 1'b1;
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (xip_ack_o) acks++;
      end
      chk("t5_no_late_ack", acks, 32'd0);
      m_flash = 32'hC0FFEE00;
      xip_read(24'h00ABCD, d, cs_hi, cs_ok, tmo, dacks);
      chk("t5_timeout", {31'b0, tmo}, 32'd0);
      chk("t5_dat", d, 32'h00EEFFC0);
      if (tx_q.size() == 2) chk("t5_cmd", tx_q[0], 32'h0300ABCC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
